// File: rtl/writeback_queue_pkg.sv
// wb_pkg: shared widths and the stored entry type for writeback_queue.
package wb_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/writeback_queue_mem.sv
// writeback_queue_mem: DEPTH-entry storage, two write and two read ports, no data reset.
// With WB_QUEUE_LOOKUP_EN the whole array is also exposed for the bypass search.
module writeback_queue_mem
  import wb_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we0_i,
  input  logic [PW-1:0] wa0_i,
  input  wb_entry_t     wd0_i,
  input  logic          we1_i,
  input  logic [PW-1:0] wa1_i,
  input  wb_entry_t     wd1_i,
  input  logic [PW-1:0] ra0_i,
  input  logic [PW-1:0] ra1_i,
  output wb_entry_t     rd0_o,
  output wb_entry_t     rd1_o
`ifdef WB_QUEUE_LOOKUP_EN
  , output wb_entry_t   ents_o [DEPTH]
`endif
);
  wb_entry_t mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we0_i) mem_q[wa0_i] <= wd0_i;
    if (we1_i) mem_q[wa1_i] <= wd1_i;
  end
  assign rd0_o = mem_q[ra0_i];
  assign rd1_o = mem_q[ra1_i];
`ifdef WB_QUEUE_LOOKUP_EN
  assign ents_o = mem_q;
`endif
endmodule

// File: rtl/writeback_queue.sv
// writeback_queue: dual-issue in-order writeback FIFO driving a two-port register file.
// Optional WB_QUEUE_LOOKUP_EN adds a youngest-match lookup for decode operand bypass.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in0_valid,
  input  logic [REG_W-1:0]  in0_reg,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  input  logic [REG_W-1:0]  in1_reg,
  input  logic [DATA_W-1:0] in1_data,
  output logic              in_ready,
  input  logic              drain_en,
  output logic              wr_en1,
  output logic [REG_W-1:0]  wr_reg1,
  output logic [DATA_W-1:0] wr_data1,
  output logic              wr_en2,
  output logic [REG_W-1:0]  wr_reg2,
  output logic [DATA_W-1:0] wr_data2,
  output logic [CW-1:0]     count
`ifdef WB_QUEUE_LOOKUP_EN
  , input  logic [REG_W-1:0]  query_reg
  , output logic              query_hit
  , output logic [DATA_W-1:0] query_data
`endif
);
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d, pushes, pops;
  logic push0, push1, has2, coll;
  wb_entry_t h, h1;
`ifdef WB_QUEUE_LOOKUP_EN
  wb_entry_t ents [DEPTH];
`endif
  assign in_ready = count_q <= CW'(DEPTH - 2);
  assign push0 = in_ready && in0_valid && in0_reg != '0;
  assign push1 = in_ready && in1_valid && in1_reg != '0;
  writeback_queue_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we0_i (push0 || push1),
    .wa0_i (tail_q),
    .wd0_i (push0 ? wb_entry_t'{in0_reg, in0_data} : wb_entry_t'{in1_reg, in1_data}),
    .we1_i (push0 && push1),
    .wa1_i (tail_q + PW'(1)),
    .wd1_i (wb_entry_t'{in1_reg, in1_data}),
    .ra0_i (head_q),
    .ra1_i (head_q + PW'(1)),
    .rd0_o (h),
    .rd1_o (h1)
`ifdef WB_QUEUE_LOOKUP_EN
    , .ents_o (ents)
`endif
  );
  // A same-destination pair collapses to one write of the younger data but still pops both.
  assign has2 = count_q >= CW'(2);
  assign coll = has2 && h.rd == h1.rd;
  assign wr_en1 = drain_en && count_q != '0;
  assign wr_en2 = drain_en && has2 && !coll;
  assign wr_reg1 = wr_en1 ? (coll ? h1.rd : h.rd) : '0;
  assign wr_data1 = wr_en1 ? (coll ? h1.data : h.data) : '0;
  assign wr_reg2 = wr_en2 ? h1.rd : '0;
  assign wr_data2 = wr_en2 ? h1.data : '0;
  assign pushes = CW'(push0) + CW'(push1);
  assign pops = !drain_en ? '0 : has2 ? CW'(2) : CW'(count_q != '0);
  assign count_d = count_q + pushes - pops;
  assign head_d = head_q + pops[PW-1:0];
  assign tail_d = tail_q + pushes[PW-1:0];
  assign count = count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
`ifdef WB_QUEUE_LOOKUP_EN
  // Walk oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    query_hit = 1'b0;
    query_data = '0;
    for (int k = 0; k < DEPTH; k++)
      if (!rst && query_reg != '0 && CW'(k) < count_q && ents[head_q + PW'(k)].rd == query_reg) begin
        query_hit = 1'b1;
        query_data = ents[head_q + PW'(k)].data;
      end
  end
`endif
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: directed plus random stimulus against a queue-based reference model.
// Exercises the WB_QUEUE_LOOKUP_EN lookup when that macro is defined.
module tb_writeback_queue;
  logic clk = 0, rst = 1;
  logic in0_valid = 0, in1_valid = 0, drain_en = 0;
  logic [4:0] in0_reg = 0, in1_reg = 0;
  logic [31:0] in0_data = 0, in1_data = 0;
  logic in_ready, wr_en1, wr_en2;
  logic [4:0] wr_reg1, wr_reg2;
  logic [31:0] wr_data1, wr_data2;
  logic [3:0] count;
`ifdef WB_QUEUE_LOOKUP_EN
  logic [4:0] query_reg = 0;
  logic query_hit;
  logic [31:0] query_data;
`endif
  always #5 clk = ~clk;
  writeback_queue #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_reg(in0_reg), .in0_data(in0_data),
    .in1_valid(in1_valid), .in1_reg(in1_reg), .in1_data(in1_data),
    .in_ready(in_ready), .drain_en(drain_en),
    .wr_en1(wr_en1), .wr_reg1(wr_reg1), .wr_data1(wr_data1),
    .wr_en2(wr_en2), .wr_reg2(wr_reg2), .wr_data2(wr_data2),
    .count(count)
`ifdef WB_QUEUE_LOOKUP_EN
    , .query_reg(query_reg), .query_hit(query_hit), .query_data(query_data)
`endif
  );
  typedef struct {logic [4:0] r; logic [31:0] d;} ent_t;
  ent_t q[$];
  int n_vec = 0, n_err = 0;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic set_in(bit v0, logic [4:0] r0, logic [31:0] d0, bit v1, logic [4:0] r1, logic [31:0] d1, bit de);
    in0_valid = v0; in0_reg = r0; in0_data = d0;
    in1_valid = v1; in1_reg = r1; in1_data = d1;
    drain_en = de;
  endtask
  // Inputs are set while clk is low; outputs checked 1ns later, model advanced at the posedge.
  task automatic cycle();
    ent_t e1, e2;
    bit x1, x2, rdy;
    int pops;
    #1;
    x1 = 0; x2 = 0; pops = 0;
    e1 = '{5'd0, 32'd0}; e2 = '{5'd0, 32'd0};
    if (drain_en && q.size() > 0) begin
      if (q.size() == 1) begin x1 = 1; e1 = q[0]; pops = 1; end
      else if (q[0].r == q[1].r) begin x1 = 1; e1 = q[1]; pops = 2; end
      else begin x1 = 1; x2 = 1; e1 = q[0]; e2 = q[1]; pops = 2; end
    end
    rdy = q.size() <= 6;
    chk("in_ready", in_ready, rdy);
    chk("count", count, q.size());
    chk("wr_en1", wr_en1, x1);
    chk("wr_reg1", wr_reg1, e1.r);
    chk("wr_data1", wr_data1, e1.d);
    chk("wr_en2", wr_en2, x2);
    chk("wr_reg2", wr_reg2, e2.r);
    chk("wr_data2", wr_data2, e2.d);
    chk("en2_without_en1", wr_en2 & ~wr_en1, 0);
`ifdef WB_QUEUE_LOOKUP_EN
    begin
      bit hit = 0;
      logic [31:0] qd = 0;
      if (!rst && query_reg != 0)
        foreach (q[i]) if (q[i].r == query_reg) begin hit = 1; qd = q[i].d; end
      chk("query_hit", query_hit, hit);
      chk("query_data", query_data, qd);
    end
`endif
    @(posedge clk);
    if (rst) q.delete();
    else begin
      repeat (pops) void'(q.pop_front());
      if (rdy && in0_valid && in0_reg != 0) q.push_back('{in0_reg, in0_data});
      if (rdy && in1_valid && in1_reg != 0) q.push_back('{in1_reg, in1_data});
    end
    @(negedge clk);
  endtask
  task automatic idle(bit de);
    set_in(0, 0, 0, 0, 0, 0, de);
    cycle();
  endtask
  initial begin
    set_in(1, 3, 32'h55, 1, 4, 32'h66, 1);
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_count", count, 0);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_wr_en1", wr_en1, 0);
    chk("reset_wr_en2", wr_en2, 0);
    set_in(0, 0, 0, 0, 0, 0, 1);
    // distinct pair drained as a double write
    set_in(1, 3, 32'h11, 1, 4, 32'h22, 1); cycle();
    set_in(0, 0, 0, 0, 0, 0, 1); #1;
    chk("pair_reg1", wr_reg1, 3); chk("pair_data2", wr_data2, 32'h22);
    cycle(); idle(1);
    // same destination collapses to the younger data
    set_in(1, 5, 32'hAA, 1, 5, 32'hBB, 1); cycle();
    set_in(0, 0, 0, 0, 0, 0, 1); #1;
    chk("coll_data1", wr_data1, 32'hBB); chk("coll_en2", wr_en2, 0);
    cycle(); idle(1);
    // r0 discarded
    set_in(1, 0, 32'h99, 1, 7, 32'h01, 1); cycle();
    idle(1); idle(1);
    // fill to DEPTH, fifth pair refused, then drain across the wrap
    for (int i = 0; i < 4; i++) begin
      set_in(1, 5'(2 * i + 1), $urandom, 1, 5'(2 * i + 2), $urandom, 0);
      cycle();
    end
    chk("full_count", count, 8);
    chk("full_in_ready", in_ready, 0);
    set_in(1, 20, 32'hDEAD, 1, 21, 32'hBEEF, 0); cycle();
    for (int i = 0; i < 5; i++) idle(1);
    // reset wins over push and drain with three entries queued
    set_in(1, 10, 32'h10, 1, 11, 32'h11, 0); cycle();
    set_in(0, 0, 0, 1, 12, 32'h12, 0); cycle();
    chk("pre_reset_count", count, 3);
    set_in(1, 13, 32'h13, 1, 14, 32'h14, 1);
    rst = 1; cycle(); rst = 0;
    chk("post_reset_count", count, 0);
    idle(1);
`ifdef WB_QUEUE_LOOKUP_EN
    set_in(1, 9, 32'h1, 1, 9, 32'h2, 0); cycle();
    query_reg = 9; set_in(0, 0, 0, 0, 0, 0, 0); #1;
    chk("lookup_hit", query_hit, 1); chk("lookup_data", query_data, 32'h2);
    cycle();
    query_reg = 0; idle(0);
    idle(1);
`endif
    for (int i = 0; i < 500; i++) begin
      set_in($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
             $urandom_range(0, 9) < 6);
`ifdef WB_QUEUE_LOOKUP_EN
      query_reg = 5'($urandom_range(0, 7));
`endif
      rst = $urandom_range(0, 99) == 0;
      cycle();
    end
    rst = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
Dual-issue writeback queue and the write-side producer for the two-write-port register file.
- Accepts up to two results per cycle from the execute lanes and buffers them in order in a FIFO.
- Drains up to two results per cycle onto the register file write ports.
- Resolves same-destination collisions and obeys the register file rule that port 2 is honoured only while port 1 is enabled.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 4
DATA_W, 32, result data width
REG_W, 5, register index width

Ports:
clk  input  1  clock; all state updates on posedge
rst  input  1  synchronous active-high reset
in0_valid  input  1  lane-0 (older) result valid
in0_reg  input  REG_W  lane-0 destination
in0_data  input  DATA_W  lane-0 result
in1_valid  input  1  lane-1 (younger) result valid
in1_reg  input  REG_W  lane-1 destination
in1_data  input  DATA_W  lane-1 result
in_ready  output  1  queue can accept two entries this cycle
drain_en  input  1  permit draining this cycle
wr_en1  output  1  register file write enable, port 1
wr_reg1  output  REG_W  port-1 destination
wr_data1  output  DATA_W  port-1 data
wr_en2  output  1  register file write enable, port 2
wr_reg2  output  REG_W  port-2 destination
wr_data2  output  DATA_W  port-2 data
count  output  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - head, tail and count cleared; all entries invalid.
  - Every wr_* output reads 0; in_ready=1 in the next cycle.
  - Reset wins over simultaneous enqueue and drain.
- in_ready: combinational, equal to (DEPTH - count >= 2), computed from the registered count before this cycle's drain. Inputs are ignored while in_ready=0.
- Enqueue, when in_ready=1:
  - Push in0, then in1, in program order.
  - Entries whose destination is r0 are discarded and never stored.
  - in1 valid with in0 invalid: in1 is pushed alone.
  - in0 and in1 with the same destination: both are stored.
- Drain outputs are combinational from the FIFO head (H) and head+1 (H1), gated by drain_en.
  - count=0: wr_en1=wr_en2=0.
  - count=1: port 1 carries H; wr_en2=0.
  - count>=2 and H.reg != H1.reg: port 1 carries H, port 2 carries H1.
  - count>=2 and H.reg == H1.reg: port 1 carries H1 (younger data); wr_en2=0; both entries are popped.
  - wr_en2=1 is never asserted while wr_en1=0; verification asserts this as a property.
  - When wr_en*=0, the corresponding reg and data outputs drive 0.
- Pop count: 0, 1 or 2 per posedge, matching the entries consumed above. Popping happens only when drain_en=1.
- Latency: an entry pushed at posedge N can appear on the wr ports during cycle N+1. The register file commits it on that cycle's negedge.
- count: next value = count + pushes − pops. Simultaneous push and pop of any mix is legal, and count never exceeds DEPTH.
- Pointer wrap-around: modulo DEPTH. H1 is taken as (head+1) mod DEPTH.

Optional Feature:
Macro WB_QUEUE_LOOKUP_EN.
- Defined: adds ports query_reg (input, REG_W), query_hit (output, 1) and query_data (output, DATA_W) for decode-stage operand bypass.
  - query_hit=1 when any stored entry targets query_reg.
  - query_data is the youngest matching entry, including entries currently presented on the wr ports.
  - Entries being enqueued this cycle are not visible.
  - query_reg=0 always gives hit 0. On a miss, query_data reads 0.
  - Both outputs are purely combinational and read 0 during reset.
- Undefined: these ports and the search logic are absent.

Decomposition:
- Package wb_pkg holds REG_W, DATA_W and the typedef wb_entry_t {reg, data}.
- One sub-module, writeback_queue_mem: DEPTH x wb_entry_t storage with two write ports and two read ports, with no reset on its data.
- Pointers, count, collision logic and lookup stay in writeback_queue.

Test Plan:
- Reset, then in0={r3,0x11}, in1={r4,0x22}, drain_en=1 -> next cycle wr_en1=1 r3/0x11, wr_en2=1 r4/0x22, count returns to 0.
- in0={r5,0xAA}, in1={r5,0xBB} -> next cycle wr_en1=1 r5/0xBB, wr_en2=0, both popped.
- in0={r0,0x99}, in1={r7,0x01} -> only r7 stored; port 1 carries r7/0x01, wr_en2=0.
- drain_en=0 with 4 pairs pushed (DEPTH=8) -> count=8, in_ready=0; a 5th pair is ignored. Set drain_en=1 -> 4 cycles of double writes in push order, including head wrap-around.
- rst=1 at the same posedge as a push and a drain, with count=3 -> count=0, wr_en1=wr_en2=0, in_ready=1.
- WB_QUEUE_LOOKUP_EN defined, drain_en=0, queue holds {r9,0x1},{r9,0x2} -> query_reg=9 gives hit=1, data=0x2. query_reg=0 gives hit=0.
